// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative HI/LO multiply/divide unit for the EX stage.
// Serial shift-add MULT/MULTU and restoring DIV/DIVU, 33-cycle latency.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start, op       begin operation (00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   a, b            rs / rt operands, sampled only at start
//   hiWrite/loWrite MTHI/MTLO requests with wdata, honoured only when idle
//   hiloRead        MFHI/MFLO present in ID
//   busy, stallReq  operation in progress / pipeline freeze request
//   done            one-cycle pulse after HI/LO take a result
//   hi, lo          architectural HI and LO registers
module muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hiWrite,
  input  logic        loWrite,
  input  logic [31:0] wdata,
  input  logic        hiloRead,
  output logic        busy,
  output logic        stallReq,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    FINISH
  } state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [63:0] acc;
  logic        neg_a;
  logic        neg_b;
  logic        is_div;
  logic        div_zero;

  // operand conditioning at start
  logic        in_neg_a;
  logic        in_neg_b;
  logic [31:0] in_mag_a;
  logic [31:0] in_mag_b;

  always_comb begin
    in_neg_a = ~op[0] & a[31];
    in_neg_b = ~op[0] & b[31];
    in_mag_a = in_neg_a ? (32'd0 - a) : a;
    in_mag_b = in_neg_b ? (32'd0 - b) : b;
  end

  // multiply step: acc[31:0] holds the remaining multiplier bits,
  // acc[63:32] the running partial sum; 33-bit add keeps the carry.
  logic [32:0] add_sum;
  logic [63:0] mul_next;

  always_comb begin
    add_sum  = {1'b0, acc[63:32]} + {1'b0, mag_a};
    mul_next = acc[0] ? {add_sum, acc[31:1]}
                      : {1'b0, acc[63:1]};
  end

  // restoring divide step: acc = {remainder, dividend/quotient}.
  // The shifted remainder needs 33 bits for the compare; after a
  // successful subtract it always fits back in 32.
  logic [32:0] rem_sh;
  logic        rem_ge;
  logic [31:0] rem_sub;
  logic [63:0] div_next;

  always_comb begin
    rem_sh   = acc[63:31];
    rem_ge   = rem_sh >= {1'b0, mag_b};
    rem_sub  = rem_sh[31:0] - mag_b;
    div_next = rem_ge ? {rem_sub, acc[30:0], 1'b1}
                      : {acc[62:0], 1'b0};
  end

  // sign fix-up; divide-by-zero forces an all-ones quotient while the
  // remainder path already reproduces the original dividend
  logic [63:0] prod;
  logic [31:0] quo;
  logic [31:0] rem;

  always_comb begin
    prod = (neg_a ^ neg_b) ? (64'd0 - acc) : acc;
    quo  = div_zero ? 32'hFFFF_FFFF
         : (neg_a ^ neg_b) ? (32'd0 - acc[31:0])
         : acc[31:0];
    rem  = neg_a ? (32'd0 - acc[63:32]) : acc[63:32];
  end

  // reset gate keeps the freeze request low while reset is applied
  assign stallReq = busy & ~rst &
                    (hiloRead | start | hiWrite | loWrite);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 5'd0;
      mag_a    <= 32'd0;
      mag_b    <= 32'd0;
      acc      <= 64'd0;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
      is_div   <= 1'b0;
      div_zero <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= 32'd0;
      lo       <= 32'd0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            neg_a    <= in_neg_a;
            neg_b    <= in_neg_b;
            mag_a    <= in_mag_a;
            mag_b    <= in_mag_b;
            is_div   <= op[1];
            div_zero <= op[1] & (b == 32'd0);
            cnt      <= 5'd0;
            busy     <= 1'b1;
            acc      <= op[1] ? {32'd0, in_mag_a}
                              : {32'd0, in_mag_b};
            state    <= op[1] ? DIV : MUL;
          end else begin
            if (hiWrite) hi <= wdata;
            if (loWrite) lo <= wdata;
          end
        end
        MUL: begin
          acc <= mul_next;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) state <= FINISH;
        end
        DIV: begin
          acc <= div_next;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) state <= FINISH;
        end
        FINISH: begin
          if (is_div) begin
            hi <= rem;
            lo <= quo;
          end else begin
            hi <= prod[63:32];
            lo <= prod[31:0];
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized + directed checks of muldiv_unit
// against an arithmetic HI/LO reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        hiWrite;
  logic        loWrite;
  logic [31:0] wdata;
  logic        hiloRead;
  logic        busy;
  logic        stallReq;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  muldiv_unit dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .hiWrite  (hiWrite),
    .loWrite  (loWrite),
    .wdata    (wdata),
    .hiloRead (hiloRead),
    .busy     (busy),
    .stallReq (stallReq),
    .done     (done),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // {hi, lo} from plain signed/unsigned 64-bit arithmetic
  function automatic logic [63:0] ref_result(input logic [1:0] o,
                                             input logic [31:0] x,
                                             input logic [31:0] y);
    longint          sx = $signed(x);
    longint          sy = $signed(y);
    longint unsigned ux = {32'd0, x};
    longint unsigned uy = {32'd0, y};
    longint          q;
    longint          r;
    case (o)
      2'b00: return sx * sy;
      2'b01: return ux * uy;
      2'b10: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        q = longint'(ux / uy);
        r = longint'(ux % uy);
        return {r[31:0], q[31:0]};
      end
    endcase
  endfunction

  task automatic run_op(input logic [1:0] o,
                        input logic [31:0] x,
                        input logic [31:0] y,
                        input logic hr,
                        input string tag);
    int n;
    int stalls;
    logic [63:0] e;
    e = ref_result(o, x, y);
    @(negedge clk);
    start    = 1'b1;
    op       = o;
    a        = x;
    b        = y;
    hiloRead = hr;
    @(posedge clk);
    #1;
    start = 1'b0;
    check({tag, "_busy"}, busy, 1'b1);
    n = 0;
    stalls = 0;
    while (!done && n < 40) begin
      if (stallReq) stalls++;
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_lat"}, n, 33);
    check({tag, "_res"}, {hi, lo}, e);
    if (hr) begin
      check({tag, "_stalln"}, stalls, 33);
      check({tag, "_stallend"}, stallReq, 1'b0);
    end
    hiloRead = 1'b0;
    exp_hi = e[63:32];
    exp_lo = e[31:0];
    @(posedge clk);
    #1;
    check({tag, "_pulse"}, {busy, done}, 2'b00);
  endtask

  initial begin
    int n;
    int dn;
    logic [1:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    rst = 1'b1;
    start = 1'b0;
    op = 2'b00;
    a = 32'd0;
    b = 32'd0;
    hiWrite = 1'b0;
    loWrite = 1'b0;
    wdata = 32'd0;
    hiloRead = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", {busy, done, stallReq}, 3'b000);
    check("rst_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    hiloRead = 1'b0;

    run_op(2'b00, 32'hFFFF_FFFD, 32'd5, 1'b0, "mult_neg");
    check("mult_neg_k", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    run_op(2'b11, 32'd100, 32'd7, 1'b0, "divu");
    check("divu_k", {hi, lo}, {32'd2, 32'd14});
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, "div_neg");
    check("div_neg_k", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(2'b10, 32'h1234_5678, 32'd0, 1'b0, "div_z");
    check("div_z_k", {hi, lo}, 64'h1234_5678_FFFF_FFFF);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");
    check("div_ovf_k", {hi, lo}, 64'h0000_0000_8000_0000);
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, "multu");
    check("multu_k", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    run_op(2'b11, 32'h8765_4321, 32'd0, 1'b0, "divu_z");

    // idle MTHI / MTLO
    @(negedge clk);
    hiWrite = 1'b1;
    wdata = 32'hA5A5_A5A5;
    @(posedge clk);
    #1;
    hiWrite = 1'b0;
    check("mthi", hi, 32'hA5A5_A5A5);
    check("mthi_lo", lo, exp_lo);
    @(negedge clk);
    hiWrite = 1'b1;
    loWrite = 1'b1;
    wdata = 32'h1111_1111;
    @(posedge clk);
    #1;
    hiWrite = 1'b0;
    loWrite = 1'b0;
    check("mthilo", {hi, lo}, {2{32'h1111_1111}});

    // start wins over loWrite; loWrite while busy stalls and is dropped
    @(negedge clk);
    start = 1'b1;
    op = 2'b00;
    a = 32'd6;
    b = 32'd7;
    loWrite = 1'b1;
    wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    start = 1'b0;
    loWrite = 1'b0;
    check("start_wins", lo, 32'h1111_1111);
    @(negedge clk);
    loWrite = 1'b1;
    wdata = 32'hCAFE_F00D;
    #1;
    check("busy_stall", stallReq, 1'b1);
    @(posedge clk);
    #1;
    check("busy_mtlo", lo, 32'h1111_1111);
    @(negedge clk);
    loWrite = 1'b0;
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("mul67", {hi, lo}, 64'd42);

    // reset in the middle of a DIV
    @(negedge clk);
    start = 1'b1;
    op = 2'b10;
    a = 32'd1000;
    b = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    hiloRead = 1'b1;
    #1;
    check("rst_mid_stall", stallReq, 1'b0);
    @(posedge clk);
    #1;
    check("rst_mid", {busy, done, stallReq}, 3'b000);
    check("rst_mid_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_after_stall", stallReq, 1'b0);
    hiloRead = 1'b0;
    dn = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) dn++;
    end
    check("rst_no_done", dn, 0);
    check("rst_hold", {hi, lo}, 64'd0);
    run_op(2'b00, 32'd6, 32'd7, 1'b0, "post_rst");

    // randomized operations
    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 9));
        2: ra = 32'($urandom_range(0, 200));
        3: rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        default: ;
      endcase
      run_op(ro, ra, rb, 1'($urandom_range(0, 1)), "rnd");
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
